// File: rtl/stepper_axis_driver.sv
// Stepper axis driver: step/dir pulse generator with signed position counter.
// Optional soft position limits enabled by defining STEPPER_SOFT_LIMIT_EN.
module stepper_axis_driver #(
  parameter int unsigned       PRESCALE    = 100,
  parameter int unsigned       PULSE_WIDTH = 200,
  parameter int unsigned       DIR_SETUP   = 100,
  parameter logic signed [31:0] POS_MIN    = -32'sd20000,
  parameter logic signed [31:0] POS_MAX    = 32'sd20000
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic [31:0] speed_in,
  input  logic [31:0] dir_in,
  input  logic        home_in,
  output logic        step_out,
  output logic        dir_out,
  output logic [31:0] current_pos,
  output logic        busy,
  output logic        limit_hit
);

`ifdef STEPPER_SOFT_LIMIT_EN
  localparam logic LimEn = 1'b1;
`else
  localparam logic LimEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE, SETUP, HIGH, LOW
  } state_t;

  state_t state, stateN;
  logic [31:0] setupCnt, setupN;
  logic [31:0] pulseCnt, pulseN;
  logic [47:0] elapsed;
  logic [47:0] period, periodN;
  logic        stepN, dirN, limitN, rise;
  logic signed [31:0] pos;
  logic [15:0] speed;
  logic        blocked;
  logic        unusedBits;

  assign speed      = speed_in[15:0];
  assign unusedBits = ^{speed_in[31:16], dir_in[31:1]};

  function automatic logic [47:0] calcPeriod(input logic [15:0] spd);
    logic [47:0] raw;
    logic [47:0] minT;
    raw  = 48'(spd) * 48'(PRESCALE);
    minT = 48'(PULSE_WIDTH) << 1;
    return (raw > minT) ? raw : minT;
  endfunction

  // A rising edge is withheld when the next step would pass a soft limit
  assign blocked = LimEn &
    ((dir_out && (pos >= POS_MAX)) ||
     (!dir_out && (pos <= POS_MIN)));

  assign busy        = (state != IDLE);
  assign current_pos = pos;

  // Next-state and registered-output decisions
  always_comb begin
    stateN  = state;
    setupN  = setupCnt;
    pulseN  = pulseCnt;
    periodN = period;
    stepN   = step_out;
    dirN    = dir_out;
    limitN  = 1'b0;
    rise    = 1'b0;
    unique case (state)
      IDLE: begin
        if (speed != 16'd0) begin
          stateN  = SETUP;
          dirN    = dir_in[0];
          setupN  = 32'(DIR_SETUP);
          periodN = calcPeriod(speed);
        end
      end
      SETUP: begin
        if (setupCnt <= 32'd1) begin
          if (blocked) begin
            limitN = 1'b1;
          end else begin
            stateN = HIGH;
            stepN  = 1'b1;
            rise   = 1'b1;
            pulseN = 32'(PULSE_WIDTH);
          end
        end else begin
          setupN = setupCnt - 32'd1;
        end
      end
      HIGH: begin
        if (pulseCnt <= 32'd1) begin
          stateN = LOW;
          stepN  = 1'b0;
        end else begin
          pulseN = pulseCnt - 32'd1;
        end
      end
      LOW: begin
        if (elapsed >= period) begin
          if (speed == 16'd0) begin
            stateN = IDLE;
          end else if (dir_in[0] != dir_out) begin
            stateN  = SETUP;
            dirN    = dir_in[0];
            setupN  = 32'(DIR_SETUP);
            periodN = calcPeriod(speed);
          end else if (blocked) begin
            limitN = 1'b1;
          end else begin
            stateN  = HIGH;
            stepN   = 1'b1;
            rise    = 1'b1;
            pulseN  = 32'(PULSE_WIDTH);
            periodN = calcPeriod(speed);
          end
        end
      end
      default: stateN = IDLE;
    endcase
  end

  // State, counters and pin registers
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state     <= IDLE;
      setupCnt  <= '0;
      pulseCnt  <= '0;
      period    <= '0;
      elapsed   <= '0;
      step_out  <= 1'b0;
      dir_out   <= 1'b0;
      limit_hit <= 1'b0;
    end else begin
      state     <= stateN;
      setupCnt  <= setupN;
      pulseCnt  <= pulseN;
      period    <= periodN;
      step_out  <= stepN;
      dir_out   <= dirN;
      limit_hit <= limitN;
      if (rise)
        elapsed <= 48'd1;
      else if (elapsed != '1)
        elapsed <= elapsed + 48'd1;
    end
  end

  // Position: homing overrides the step update
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n)
      pos <= '0;
    else if (home_in)
      pos <= '0;
    else if (rise)
      pos <= dir_out ? (pos + 32'sd1) : (pos - 32'sd1);
  end

endmodule
